// File: rtl/alsu_pkg.sv
// Shared ALSU definitions: datapath widths, select-group encodings and the
// command entry carried by the issue stage FIFO.
package alsu_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned SEL_W  = 5;

  // sel[4:3] group encodings
  localparam logic [1:0] GRP_LOGIC         = 2'b00;
  localparam logic [1:0] GRP_NAND_NOR      = 2'b01;
  localparam logic [1:0] GRP_BYPASS_EQ_SLT = 2'b10;
  localparam logic [1:0] GRP_SHIFT_ROTATE  = 2'b11;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] a;
  } cmd_t;

  typedef struct packed {
    logic chain;
    cmd_t cmd;
  } chain_cmd_t;

  localparam int unsigned CMD_W       = $bits(cmd_t);
  localparam int unsigned CHAIN_CMD_W = $bits(chain_cmd_t);

  function automatic logic is_zero(input logic [DATA_W-1:0] d);
    return d == '0;
  endfunction

endpackage

// File: rtl/alsu_cmd_fifo.sv
// Circular command FIFO with occupancy count; pushes are refused when full
// even if a pop happens in the same cycle, pops are refused when empty.
module alsu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 13,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [W-1:0]     wdata_i,
  input  logic             pop_i,
  output logic [W-1:0]     rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alsu_logic_issue_stage.sv
// Issue/retire stage in front of the ALSU logic unit: FIFO-buffered requests,
// head presented to the unit, result captured behind a valid/ready port.
// Optional feature macro: ALSU_CHAIN_EN (head A replaced by last captured result).
module alsu_logic_issue_stage
  import alsu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic [4:0]       in_sel,
  input  logic             in_chain,
  output logic [3:0]       lu_a,
  output logic [3:0]       lu_b,
  output logic [4:0]       lu_sel,
  input  logic [3:0]       lu_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [4:0]       out_sel,
  output logic             out_zero,
  output logic [CNT_W-1:0] fifo_count
);

`ifdef ALSU_CHAIN_EN
  localparam int unsigned ENT_W = CHAIN_CMD_W;
`else
  localparam int unsigned ENT_W = CMD_W;
`endif

  logic [ENT_W-1:0]  wdata, rdata;
  cmd_t              head_cmd;
  logic              full, empty, push, pop;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic              out_zero_q, out_zero_d;

`ifdef ALSU_CHAIN_EN
  logic head_chain;
  assign wdata      = {in_chain, in_sel, in_b, in_a};
  assign head_chain = rdata[ENT_W-1];
  assign head_cmd   = rdata[CMD_W-1:0];
`else
  logic unused_chain;
  assign unused_chain = in_chain;
  assign wdata        = {in_sel, in_b, in_a};
  assign head_cmd     = rdata;
`endif

  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = !empty && (!out_valid_q || out_ready);

  alsu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  // Head presentation; a chained head takes A from the previously captured result
  always_comb begin
    lu_a   = '0;
    lu_b   = '0;
    lu_sel = '0;
    if (!empty) begin
      lu_a   = head_cmd.a;
      lu_b   = head_cmd.b;
      lu_sel = head_cmd.sel;
`ifdef ALSU_CHAIN_EN
      if (head_chain) lu_a = out_data_q;
`endif
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_zero_d  = out_zero_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = lu_out;
      out_sel_d   = lu_sel;
      out_zero_d  = is_zero(lu_out);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_zero_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_alsu_logic_issue_stage.sv
// Self-checking bench for alsu_logic_issue_stage: behavioural logic unit,
// in-order result queue model, directed and random scenarios.
module tb_alsu_logic_issue_stage;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_a = '0;
  logic [3:0]       in_b = '0;
  logic [4:0]       in_sel = '0;
  logic             in_chain = 1'b0;
  logic [3:0]       lu_a, lu_b, lu_out;
  logic [4:0]       lu_sel;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       out_data;
  logic [4:0]       out_sel;
  logic             out_zero;
  logic [CNT_W-1:0] fifo_count;

  alsu_logic_issue_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_chain(in_chain),
    .lu_a(lu_a), .lu_b(lu_b), .lu_sel(lu_sel), .lu_out(lu_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .out_zero(out_zero),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Behavioural logic/shift unit feeding lu_out
  function automatic logic [3:0] lu_model(input logic [3:0] a, input logic [3:0] b,
                                          input logic [4:0] sel);
    logic [7:0] t;
    case (sel[4:3])
      2'b00: case (sel[2:0])
        3'd0: return a & b;
        3'd1: return a | b;
        3'd2: return a ^ b;
        3'd3: return ~(a ^ b);
        default: return ~a;
      endcase
      2'b01: return sel[0] ? ~(a | b) : ~(a & b);
      2'b10: case (sel[1:0])
        2'd0: return a;
        2'd1: return b;
        2'd2: return {3'b000, a == b};
        default: return {3'b000, a < b};
      endcase
      default: case (sel[1:0])
        2'd0: return a << b[1:0];
        2'd1: return a >> b[1:0];
        2'd2: begin t = {a, a} << b[1:0]; return t[7:4]; end
        default: begin t = {a, a} >> b[1:0]; return t[3:0]; end
      endcase
    endcase
  endfunction

  assign lu_out = lu_model(lu_a, lu_b, lu_sel);

  typedef struct { logic [3:0] data; logic [4:0] sel; } exp_t;
  exp_t       exp_q[$];
  logic [3:0] last_res = '0;
  int         n_cmp = 0;
  int         n_fail = 0;

  task automatic model_push(input logic [3:0] a, input logic [3:0] b,
                            input logic [4:0] sel, input logic chain);
    logic [3:0] a_eff;
    exp_t e;
    a_eff = a;
`ifdef ALSU_CHAIN_EN
    if (chain) a_eff = last_res;
`else
    if (chain) a_eff = a;
`endif
    e.data = lu_model(a_eff, b, sel);
    e.sel  = sel;
    last_res = e.data;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_res = '0;
  endtask

  // One clock: records handshakes seen before the edge, then samples after it
  task automatic tick(output bit acc, output bit ret, output logic [3:0] rd,
                      output logic [4:0] rs);
    acc = rst_n && in_valid && in_ready;
    ret = rst_n && out_valid && out_ready;
    rd  = out_data;
    rs  = out_sel;
    if (acc) model_push(in_a, in_b, in_sel, in_chain);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(input logic v);
    in_valid = v;
    in_a     = 4'($urandom);
    in_b     = 4'($urandom);
    in_sel   = 5'($urandom);
    in_chain = 1'($urandom);
  endtask

  task automatic test_reset();
    bit acc, ret; logic [3:0] rd; logic [4:0] rs;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(acc, ret, rd, rs);
    tick(acc, ret, rd, rs);
    rst_n = 1'b1;
    model_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 4'h0 || out_sel !== 5'h00 || out_zero !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_regs: got data=%h sel=%b zero=%b want 0/0/0", out_data, out_sel, out_zero); end
    n_cmp++; if (fifo_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_cmp++; if (lu_a !== 4'h0 || lu_b !== 4'h0 || lu_sel !== 5'h00) begin
      n_fail++; $display("FAIL reset_lu: got a=%h b=%h sel=%b want zeros", lu_a, lu_b, lu_sel); end
  endtask

  task automatic test_single();
    bit acc, ret; logic [3:0] rd; logic [4:0] rs; exp_t e;
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 4'hC; in_b = 4'hA; in_sel = 5'b00000; in_chain = 1'b0;
    tick(acc, ret, rd, rs);
    in_valid = 1'b0;
    n_cmp++; if (fifo_count !== CNT_W'(1) || out_valid !== 1'b0 || lu_a !== 4'hC) begin
      n_fail++; $display("FAIL single_n1: got count=%0d valid=%b lu_a=%h want 1/0/c", fifo_count, out_valid, lu_a); end
    tick(acc, ret, rd, rs);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'h8 || out_zero !== 1'b0 || out_sel !== 5'b00000) begin
      n_fail++; $display("FAIL single_n2: got valid=%b data=%h zero=%b sel=%b want 1/8/0/00000",
                         out_valid, out_data, out_zero, out_sel); end
    out_ready = 1'b1;
    tick(acc, ret, rd, rs);
    n_cmp++;
    if (!ret || exp_q.size() == 0) begin n_fail++; $display("FAIL single_retire: ret=%b queued=%0d want 1/1", ret, exp_q.size()); end
    else begin
      e = exp_q.pop_front();
      if (rd !== e.data || rs !== e.sel) begin n_fail++; $display("FAIL single_data: got %h/%b want %h/%b", rd, rs, e.data, e.sel); end
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    bit acc, ret; logic [3:0] rd; logic [4:0] rs; exp_t e; int retired, maxcnt;
    retired = 0; maxcnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_rand(i < 8);
      tick(acc, ret, rd, rs);
      if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
      if (ret) begin
        retired++;
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_extra: unexpected result %h", rd); end
        else begin
          e = exp_q.pop_front();
          if (rd !== e.data || rs !== e.sel) begin n_fail++; $display("FAIL b2b_data: got %h/%b want %h/%b", rd, rs, e.data, e.sel); end
        end
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (retired != 8) begin n_fail++; $display("FAIL b2b_rate: got %0d retired in 10 cycles want 8", retired); end
    n_cmp++; if (maxcnt > 1) begin n_fail++; $display("FAIL b2b_count: got max count %0d want <=1", maxcnt); end
  endtask

  task automatic test_backpressure();
    bit acc, ret; logic [3:0] rd; logic [4:0] rs; exp_t e; int accepted;
    accepted = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_rand(1'b1);
      tick(acc, ret, rd, rs);
      if (acc) accepted++;
    end
    n_cmp++; if (accepted != DEPTH + 1) begin n_fail++; $display("FAIL bp_accepted: got %0d want %0d", accepted, DEPTH + 1); end
    n_cmp++; if (in_ready !== 1'b0 || fifo_count !== CNT_W'(DEPTH) || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_full: got ready=%b count=%0d valid=%b want 0/%0d/1", in_ready, fifo_count, out_valid, DEPTH); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      tick(acc, ret, rd, rs);
      if (ret) begin
        n_cmp++;
        e = exp_q.pop_front();
        if (rd !== e.data || rs !== e.sel) begin n_fail++; $display("FAIL bp_data: got %h/%b want %h/%b", rd, rs, e.data, e.sel); end
      end
    end
    tick(acc, ret, rd, rs);
    n_cmp++; if (exp_q.size() != 0 || out_valid !== 1'b0 || fifo_count !== '0) begin
      n_fail++; $display("FAIL bp_drain: got left=%0d valid=%b count=%0d want 0/0/0", exp_q.size(), out_valid, fifo_count); end
  endtask

  task automatic test_zero_hold();
    bit acc, ret; logic [3:0] rd; logic [4:0] rs; exp_t e;
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 4'h5; in_b = 4'hA; in_sel = 5'b00000; in_chain = 1'b0;
    tick(acc, ret, rd, rs);
    in_valid = 1'b0;
    tick(acc, ret, rd, rs);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'h0 || out_zero !== 1'b1) begin
      n_fail++; $display("FAIL zero_flag: got valid=%b data=%h zero=%b want 1/0/1", out_valid, out_data, out_zero); end
    for (int i = 0; i < 3; i++) begin
      tick(acc, ret, rd, rs);
      n_cmp++; if (ret || out_valid !== 1'b1 || out_data !== 4'h0 || out_zero !== 1'b1) begin
        n_fail++; $display("FAIL zero_hold: got ret=%b valid=%b data=%h zero=%b want 0/1/0/1", ret, out_valid, out_data, out_zero); end
    end
    out_ready = 1'b1;
    tick(acc, ret, rd, rs);
    n_cmp++;
    if (!ret || exp_q.size() == 0) begin n_fail++; $display("FAIL zero_retire: ret=%b queued=%0d want 1/1", ret, exp_q.size()); end
    else begin
      e = exp_q.pop_front();
      if (rd !== e.data || rs !== e.sel) begin n_fail++; $display("FAIL zero_data: got %h/%b want %h/%b", rd, rs, e.data, e.sel); end
    end
  endtask

  task automatic test_chain();
    bit acc, ret; logic [3:0] rd; logic [4:0] rs; exp_t e; logic [3:0] want_a;
`ifdef ALSU_CHAIN_EN
    want_a = 4'h3;
`else
    want_a = 4'hF;
`endif
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 4'h3; in_b = 4'h9; in_sel = 5'b10000; in_chain = 1'b0;
    tick(acc, ret, rd, rs);
    in_a = 4'hF; in_b = 4'h5; in_sel = 5'b00000; in_chain = 1'b1;
    tick(acc, ret, rd, rs);
    in_valid = 1'b0; in_chain = 1'b0;
    n_cmp++; if (lu_a !== want_a || lu_b !== 4'h5 || lu_sel !== 5'b00000) begin
      n_fail++; $display("FAIL chain_lu: got a=%h b=%h sel=%b want %h/5/00000", lu_a, lu_b, lu_sel, want_a); end
    for (int i = 0; i < 6 && exp_q.size() > 0; i++) begin
      tick(acc, ret, rd, rs);
      if (ret) begin
        n_cmp++;
        e = exp_q.pop_front();
        if (rd !== e.data || rs !== e.sel) begin n_fail++; $display("FAIL chain_data: got %h/%b want %h/%b", rd, rs, e.data, e.sel); end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL chain_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_random();
    bit acc, ret; logic [3:0] rd; logic [4:0] rs; exp_t e;
    for (int i = 0; i < 400; i++) begin
      drive_rand(1'($urandom));
      out_ready = 1'($urandom);
      tick(acc, ret, rd, rs);
      if (ret) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_extra: unexpected result %h", rd); end
        else begin
          e = exp_q.pop_front();
          if (rd !== e.data || rs !== e.sel) begin n_fail++; $display("FAIL rand_data: cycle %0d got %h/%b want %h/%b", i, rd, rs, e.data, e.sel); end
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      tick(acc, ret, rd, rs);
      if (ret) begin
        n_cmp++;
        e = exp_q.pop_front();
        if (rd !== e.data || rs !== e.sel) begin n_fail++; $display("FAIL rand_drain_data: got %h/%b want %h/%b", rd, rs, e.data, e.sel); end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit acc, ret; logic [3:0] rd; logic [4:0] rs;
    tick(acc, ret, rd, rs);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_rand(1'b1);
      tick(acc, ret, rd, rs);
    end
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || fifo_count !== CNT_W'(3)) begin
      n_fail++; $display("FAIL mid_setup: got valid=%b count=%0d want 1/3", out_valid, fifo_count); end
    rst_n = 1'b0;
    tick(acc, ret, rd, rs);
    rst_n = 1'b1;
    model_reset();
    n_cmp++; if (out_valid !== 1'b0 || fifo_count !== '0 || in_ready !== 1'b1 || out_data !== 4'h0) begin
      n_fail++; $display("FAIL mid_reset: got valid=%b count=%0d ready=%b data=%h want 0/0/1/0",
                         out_valid, fifo_count, in_ready, out_data); end
    out_ready = 1'b1;
    tick(acc, ret, rd, rs);
    tick(acc, ret, rd, rs);
    n_cmp++; if (out_valid !== 1'b0 || fifo_count !== '0 || lu_sel !== 5'h00) begin
      n_fail++; $display("FAIL mid_quiet: got valid=%b count=%0d lu_sel=%b want 0/0/0", out_valid, fifo_count, lu_sel); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_zero_hold();
    test_chain();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
